pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl_pkg.sv | 18 +
 rtl/pipeline_hazard_ctrl_if.sv | 36 +++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 21 ++
 rtl/pipeline_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   ST_*            : controller state encodings (encoding 3 is unused)
//   REG_ZERO        : hard-wired zero register; never a hazard source
//   CTRL_*_BIT      : control_signals bit positions used by the decode glue
//                     (ex_mem_read is built from CTRL_LOAD_BIT)
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam int REG_ZERO = 0;

  localparam int CTRL_LOAD_BIT   = 2;
  localparam int CTRL_STORE_BIT  = 3;
  localparam int CTRL_BRANCH_BIT = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard bundle between the pipeline datapath and the hazard controller.
//   ID/EX hazard sources : id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd,
//                          ex_mem_read, ex_branch_taken, mem_busy
//   Pipeline controls    : pc_enable, if_id_enable, if_id_flush,
//                          id_ex_flush, pipe_hold
// master = datapath side, slave = controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic                  mem_busy;

  logic                  pc_enable;
  logic                  if_id_enable;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  pipe_hold;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read,
           ex_branch_taken, mem_busy,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_flush, pipe_hold
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read,
           ex_branch_taken, mem_busy,
    output pc_enable, if_id_enable, if_id_flush, id_ex_flush, pipe_hold
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter for performance monitoring.
//   clk, reset (async, active-high), inc : count one event per cycle
//   count                                : holds at all-ones, never wraps
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   clk, reset   : clock (rising edge), async active-high reset
//   hz           : hazard bundle (ID/EX hazard sources in, pipe controls out)
//   state        : current controller state
//   stall_count  : cycles with pc_enable=0 since reset (saturating)
//   flush_count  : taken branches applied (saturating)
//
// state       | meaning
// ST_RUN      | normal flow; load-use stalls handled in place
// ST_FLUSH    | squashing the remaining wrong-path fetches after a branch
// ST_MEM_WAIT | pipe frozen on data memory; branches latched as pending
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int FL_W = (BRANCH_PENALTY > 2) ? $clog2(BRANCH_PENALTY) : 1;
  localparam logic [FL_W-1:0] FL_RELOAD = FL_W'(BRANCH_PENALTY - 1);

  logic [1:0]      state_q, state_d;
  logic [FL_W-1:0] flush_left_q, flush_left_d;
  logic            pending_br_q, pending_br_d;

  logic load_use, branch, flush_active, br_apply;
  logic pc_en;

  assign load_use = hz.ex_mem_read
                  & (hz.ex_rd != REG_ADDR_W'(REG_ZERO))
                  & ((hz.id_uses_rs & (hz.id_rs == hz.ex_rd))
                   | (hz.id_uses_rt & (hz.id_rt == hz.ex_rd)));
  assign branch       = hz.ex_branch_taken | pending_br_q;
  assign flush_active = (flush_left_q != '0);
  // Only an unblocked cycle can apply a branch.
  assign br_apply     = ~hz.mem_busy & branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      flush_left_q <= '0;
      pending_br_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      pending_br_q <= pending_br_d;
    end
  end

  // Once memory is ready every state (including the unused encoding) is
  // resolved by the same priority chain, so a flush interrupted by
  // MEM_WAIT resumes from flush_left on release.
  always_comb begin
    state_d      = ST_RUN;
    flush_left_d = flush_left_q;
    pending_br_d = pending_br_q;
    if (hz.mem_busy) begin
      state_d      = ST_MEM_WAIT;
      pending_br_d = pending_br_q | hz.ex_branch_taken;
    end else if (branch) begin
      pending_br_d = 1'b0;
      flush_left_d = FL_RELOAD;
      state_d      = (FL_RELOAD != '0) ? ST_FLUSH : ST_RUN;
    end else if (flush_active) begin
      flush_left_d = flush_left_q - FL_W'(1);
      state_d      = (flush_left_q > FL_W'(1)) ? ST_FLUSH : ST_RUN;
    end
  end

  always_comb begin
    pc_en           = 1'b1;
    hz.if_id_enable = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.pipe_hold    = 1'b0;
    if (reset) begin
      pc_en           = 1'b0;
      hz.if_id_enable = 1'b0;
    end else if (hz.mem_busy) begin
      pc_en           = 1'b0;
      hz.if_id_enable = 1'b0;
      hz.pipe_hold    = 1'b1;
    end else if (branch) begin
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
    end else if (flush_active) begin
      hz.if_id_flush  = 1'b1;
    end else if (load_use) begin
      pc_en           = 1'b0;
      hz.if_id_enable = 1'b0;
      hz.id_ex_flush  = 1'b1;
    end
  end

  assign hz.pc_enable = pc_en;
  assign state        = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_en),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (br_apply),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (BRANCH_PENALTY=2).
// Control vector order: {pc_enable, if_id_enable, if_id_flush, id_ex_flush, pipe_hold}
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic [4:0]  ctl;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [4:0] C_DEF  = 5'b11000;
  localparam logic [4:0] C_LU   = 5'b00010;
  localparam logic [4:0] C_BR   = 5'b11110;
  localparam logic [4:0] C_FL   = 5'b11100;
  localparam logic [4:0] C_HOLD = 5'b00001;
  localparam logic [4:0] C_RST  = 5'b00000;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5), .BRANCH_PENALTY(2), .CNT_W(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hz          (hz),
    .state       (state),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  assign ctl = {hz.pc_enable, hz.if_id_enable, hz.if_id_flush, hz.id_ex_flush, hz.pipe_hold};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
    hz.ex_rd = '0; hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0; hz.mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    total_cnt++;
    if (ctl !== C_RST) $display("FAIL reset_ctl: got %b want %b", ctl, C_RST); else pass_cnt++;
    tick();
    tick();
    reset = 1'b0;
    #2;
    total_cnt++;
    if ({state, stall_count, flush_count} !== {2'd0, 16'd0, 16'd0})
      $display("FAIL reset_regs: got st=%0d sc=%0d fc=%0d want 0/0/0", state, stall_count, flush_count);
    else pass_cnt++;
    total_cnt++;
    if (ctl !== C_DEF) $display("FAIL reset_default_ctl: got %b want %b", ctl, C_DEF); else pass_cnt++;
  endtask

  task automatic test_load_use();
    do_reset();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs = 5'd5; hz.id_uses_rs = 1'b1;
    #2;
    total_cnt++;
    if (ctl !== C_LU) $display("FAIL load_use_rs_ctl: got %b want %b", ctl, C_LU); else pass_cnt++;
    tick();
    idle_inputs();
    #2;
    total_cnt++;
    if (ctl !== C_DEF || stall_count !== 16'd1)
      $display("FAIL load_use_after: got ctl=%b sc=%0d want %b/1", ctl, stall_count, C_DEF);
    else pass_cnt++;
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.id_rt = 5'd7; hz.id_uses_rt = 1'b1; hz.id_rs = 5'd7;
    #2;
    total_cnt++;
    if (ctl !== C_LU) $display("FAIL load_use_rt_ctl: got %b want %b", ctl, C_LU); else pass_cnt++;
    tick();
    hz.id_uses_rt = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== C_DEF || stall_count !== 16'd2)
      $display("FAIL load_use_unused_src: got ctl=%b sc=%0d want %b/2", ctl, stall_count, C_DEF);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    do_reset();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs = 5'd0; hz.id_uses_rs = 1'b1;
    #2;
    total_cnt++;
    if (ctl !== C_DEF) $display("FAIL rd_zero_ctl: got %b want %b", ctl, C_DEF); else pass_cnt++;
    tick();
    total_cnt++;
    if (stall_count !== 16'd0) $display("FAIL rd_zero_stall: got %0d want 0", stall_count); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    hz.ex_branch_taken = 1'b1;
    #2;
    total_cnt++;
    if (ctl !== C_BR || state !== 2'd0)
      $display("FAIL branch_c0: got ctl=%b st=%0d want %b/0", ctl, state, C_BR);
    else pass_cnt++;
    tick();
    hz.ex_branch_taken = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== C_FL || state !== 2'd1)
      $display("FAIL branch_c1: got ctl=%b st=%0d want %b/1", ctl, state, C_FL);
    else pass_cnt++;
    tick();
    #2;
    total_cnt++;
    if (ctl !== C_DEF || state !== 2'd0 || flush_count !== 16'd1 || stall_count !== 16'd0)
      $display("FAIL branch_c2: got ctl=%b st=%0d fc=%0d sc=%0d want %b/0/1/0",
               ctl, state, flush_count, stall_count, C_DEF);
    else pass_cnt++;
  endtask

  task automatic test_mem_busy();
    do_reset();
    hz.mem_busy = 1'b1;
    #2;
    total_cnt++;
    if (ctl !== C_HOLD || state !== 2'd0)
      $display("FAIL mem_busy_c1: got ctl=%b st=%0d want %b/0", ctl, state, C_HOLD);
    else pass_cnt++;
    tick();
    hz.ex_branch_taken = 1'b1;
    #2;
    total_cnt++;
    if (ctl !== C_HOLD || state !== 2'd2)
      $display("FAIL mem_busy_c2: got ctl=%b st=%0d want %b/2", ctl, state, C_HOLD);
    else pass_cnt++;
    tick();
    hz.ex_branch_taken = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== C_HOLD || state !== 2'd2 || flush_count !== 16'd0)
      $display("FAIL mem_busy_c3: got ctl=%b st=%0d fc=%0d want %b/2/0", ctl, state, flush_count, C_HOLD);
    else pass_cnt++;
    tick();
    hz.mem_busy = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== C_BR || state !== 2'd2 || stall_count !== 16'd3)
      $display("FAIL mem_release: got ctl=%b st=%0d sc=%0d want %b/2/3", ctl, state, stall_count, C_BR);
    else pass_cnt++;
    tick();
    #2;
    total_cnt++;
    if (ctl !== C_FL || state !== 2'd1 || flush_count !== 16'd1)
      $display("FAIL mem_pending_flush: got ctl=%b st=%0d fc=%0d want %b/1/1", ctl, state, flush_count, C_FL);
    else pass_cnt++;
    tick();
    #2;
    total_cnt++;
    if (ctl !== C_DEF || state !== 2'd0 || stall_count !== 16'd3)
      $display("FAIL mem_done: got ctl=%b st=%0d sc=%0d want %b/0/3", ctl, state, stall_count, C_DEF);
    else pass_cnt++;
  endtask

  task automatic test_load_and_branch();
    do_reset();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd9; hz.id_rs = 5'd9; hz.id_uses_rs = 1'b1;
    hz.ex_branch_taken = 1'b1;
    #2;
    total_cnt++;
    if (ctl !== C_BR) $display("FAIL load_and_branch_ctl: got %b want %b", ctl, C_BR); else pass_cnt++;
    tick();
    idle_inputs();
    #2;
    total_cnt++;
    if (stall_count !== 16'd0 || flush_count !== 16'd1 || state !== 2'd1)
      $display("FAIL load_and_branch_cnt: got sc=%0d fc=%0d st=%0d want 0/1/1", stall_count, flush_count, state);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    hz.ex_branch_taken = 1'b1;
    tick();
    #2;
    total_cnt++;
    if (ctl !== C_BR || state !== 2'd1)
      $display("FAIL b2b_restart: got ctl=%b st=%0d want %b/1", ctl, state, C_BR);
    else pass_cnt++;
    tick();
    hz.ex_branch_taken = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== C_FL || state !== 2'd1 || flush_count !== 16'd2)
      $display("FAIL b2b_reload: got ctl=%b st=%0d fc=%0d want %b/1/2", ctl, state, flush_count, C_FL);
    else pass_cnt++;
    tick();
    #2;
    total_cnt++;
    if (ctl !== C_DEF || state !== 2'd0)
      $display("FAIL b2b_done: got ctl=%b st=%0d want %b/0", ctl, state, C_DEF);
    else pass_cnt++;
  endtask

  task automatic test_flush_freeze();
    do_reset();
    hz.ex_branch_taken = 1'b1;
    tick();
    hz.ex_branch_taken = 1'b0;
    hz.mem_busy = 1'b1;
    #2;
    total_cnt++;
    if (ctl !== C_HOLD || state !== 2'd1)
      $display("FAIL freeze_hold: got ctl=%b st=%0d want %b/1", ctl, state, C_HOLD);
    else pass_cnt++;
    tick();
    hz.mem_busy = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== C_FL || state !== 2'd2)
      $display("FAIL freeze_resume: got ctl=%b st=%0d want %b/2", ctl, state, C_FL);
    else pass_cnt++;
    tick();
    #2;
    total_cnt++;
    if (ctl !== C_DEF || state !== 2'd0 || stall_count !== 16'd1 || flush_count !== 16'd1)
      $display("FAIL freeze_done: got ctl=%b st=%0d sc=%0d fc=%0d want %b/0/1/1",
               ctl, state, stall_count, flush_count, C_DEF);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    hz.ex_branch_taken = 1'b1;
    tick();
    hz.ex_branch_taken = 1'b0;
    #2;
    total_cnt++;
    if (state !== 2'd1) $display("FAIL mid_flush_state: got %0d want 1", state); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (ctl !== C_RST || state !== 2'd0 || flush_count !== 16'd0)
      $display("FAIL mid_flush_async: got ctl=%b st=%0d fc=%0d want %b/0/0", ctl, state, flush_count, C_RST);
    else pass_cnt++;
    tick();
    tick();
    reset = 1'b0;
    #2;
    total_cnt++;
    if (ctl !== C_DEF || state !== 2'd0)
      $display("FAIL mid_flush_release: got ctl=%b st=%0d want %b/0", ctl, state, C_DEF);
    else pass_cnt++;
    tick();
    #2;
    total_cnt++;
    if (ctl !== C_DEF || state !== 2'd0 || stall_count !== 16'd0 || flush_count !== 16'd0)
      $display("FAIL mid_flush_residual: got ctl=%b st=%0d sc=%0d fc=%0d want %b/0/0/0",
               ctl, state, stall_count, flush_count, C_DEF);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch();
    test_mem_busy();
    test_load_and_branch();
    test_back_to_back();
    test_flush_freeze();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
